cla_adder_pipe: RTL and testbench
=================================

// Module: cla_adder_pipe
// PURPOSE
//   Parametrised, pipelined carry-look-ahead adder/subtractor. It is the next generation of the
//   4-bit CLA adder: any WIDTH, built from GROUP-bit lookahead groups with one register stage per group.
//   Has valid/ready handshakes on both sides, an add/subtract mode and a signed-overflow flag.
//   Sits between operand producers and result consumers in the arithmetic datapath at full throughput.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of GROUP (elaboration error otherwise)
//   GROUP   4  bits per lookahead group; also the bits resolved per pipeline stage
//   (derived) NGRP = WIDTH/GROUP = pipeline depth = latency in cycles
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      A/B/Cin/Sub are valid this cycle
//   in_ready   out  1      block accepts the input this cycle (transfer = in_valid & in_ready)
//   A          in   WIDTH  operand A, unsigned or two's complement
//   B          in   WIDTH  operand B
//   Cin        in   1      carry in; ignored when Sub=1
//   Sub        in   1      0: A+B+Cin   1: A-B (A + ~B + 1)
//   out_valid  out  1      Sum/Cout/Ovf are valid
//   out_ready  in   1      consumer takes the result (transfer = out_valid & out_ready)
//   Sum        out  WIDTH  result bits
//   Cout       out  1      carry out of MSB; for Sub=1, 1 = no borrow (A>=B unsigned)
//   Ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   - Reset (async, immediate): all stage valid bits=0, out_valid=0, Sum=0, Cout=0, Ovf=0, in_ready=1
//     once rst is released. Data regs other than outputs need not be reset. No transaction survives reset.
//   - Operand prep at input: Beff = Sub ? ~B : B; c0 = Sub ? 1 : Cin.
//   - Stage k (0..NGRP-1) registers: valid, carry into group k, sum bits [k*GROUP-1:0] already done,
//     remaining A/Beff upper bits, and carry into group MSB (for Ovf at last stage).
//   - Group logic is flat lookahead: P=a^b, G=a&b; c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]c0,
//     written as a sum of products with no ripple chain. Group sum s[i]=P[i]^c[i]; group carry-out
//     goes to the next stage.
//   - Stage 0 operates on the input and registers into stage 0. The last stage's register holds the
//     outputs (Sum/Cout/Ovf/out_valid).
//   - Latency: input accepted at edge t -> out_valid=1 after edge t+NGRP-1 (NGRP register stages,
//     the last one being the output). Throughput is 1 result/cycle when out_ready=1.
//   - Flow control, bubble-collapsing: stage k loads iff (!valid[k] | advance[k+1]);
//     advance[last] = out_ready | !out_valid. in_ready = load condition of stage 0 (combinational from
//     out_ready through the stall chain is permitted).
//   - Stall: while out_valid & !out_ready, Sum/Cout/Ovf/out_valid hold stable. Upper stages fill
//     bubbles; when all NGRP stages are valid, in_ready=0.
//   - Order preserved; no drop or duplication under any in_valid/out_ready pattern.
//   - A stage whose valid=0 may hold stale data; its data must never reach the outputs.
//   - Simultaneous output transfer and new arrival at the last stage: the new result replaces the old
//     one in the same cycle, and out_valid stays 1.
//   - in_valid=1 with in_ready=0: the input is not captured; the producer holds it (standard rule).
//   - Wrap-around: the result is modulo 2^WIDTH, and Cout/Ovf report the overflow. No saturation.
// TESTING (WIDTH=16, GROUP=4, latency 4)
//   1. A=0x0002 B=0x000F Cin=0 Sub=0 -> Sum=0x0011 Cout=0 Ovf=0; out_valid 4 cycles after accept.
//   2. A=0xFFFF B=0x0001 Cin=0 -> Sum=0x0000 Cout=1 Ovf=0 (carry through all 4 stages);
//      A=0xFFFF B=0x0000 Cin=1 -> same result.
//   3. A=0x7FFF B=0x0001 -> Sum=0x8000 Cout=0 Ovf=1; A=0x8000 B=0x8000 -> Sum=0x0000 Cout=1 Ovf=1.
//   4. Sub=1: A=0x000E B=0x0005 -> Sum=0x0009 Cout=1; A=0x0005 B=0x000E Cin=1 -> Sum=0xFFF7 Cout=0
//      (Cin ignored).
//   5. 10 back-to-back inputs with out_ready=0 in cycles 3-8: in_ready falls when 4 stages are full,
//      outputs hold stable during the stall, and all 10 results appear in order with none lost.
//   6. rst pulsed mid-stream with 3 in flight: out_valid=0 immediately, then no stale result after
//      release; after that, 1000 random ops with random in_valid/out_ready are checked against a
//      behavioural (A+B+c0) model.

Source files
------------

// File: rtl/cla_adder_pipe.sv
// Pipelined carry-look-ahead adder/subtractor: one GROUP-bit lookahead group per register stage,
// valid/ready on both sides with bubble-collapsing flow control.
module cla_adder_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    localparam int unsigned NGRP = WIDTH / GROUP;
    localparam int unsigned NREM = (NGRP > 1) ? NGRP - 1 : 1;

    if ((WIDTH % GROUP) != 0) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
    end

    // Flat sum-of-products lookahead: every carry is built directly from P/G/c0, no ripple.
    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] a,
                                                   input logic [GROUP-1:0] b,
                                                   input logic             c0);
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] g;
        logic [GROUP:0]   c;
        logic             term;
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = c0;
        for (int unsigned i = 0; i < GROUP; i++) begin
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
            term = c0;
            for (int unsigned m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = c[i+1] | term;
        end
        return c;
    endfunction

    logic [WIDTH-1:0] beff;
    logic             c0;
    logic [NGRP-1:0]  valid_q;
    logic [NGRP-1:0]  valid_d;
    logic [NGRP-1:0]  load;
    logic [NGRP-1:0]  stage_vin;

    logic [WIDTH-1:0] a_q   [NREM];
    logic [WIDTH-1:0] b_q   [NREM];
    logic [WIDTH-1:0] sum_q [NREM];
    logic [NREM-1:0]  c_q;

    logic [WIDTH-1:0] sum_o_q;
    logic             cout_q;
    logic             ovf_q;

    assign beff = Sub ? ~B : B;
    assign c0   = Sub ? 1'b1 : Cin;

    // Stage k loads when it or any stage downstream of it has room; unrolled to avoid a comb loop.
    for (genvar k = 0; k < NGRP; k++) begin : g_load
        assign load[k] = out_ready | ~(&valid_q[NGRP-1:k]);
    end

    assign in_ready  = load[0];
    assign valid_d   = (load & stage_vin) | (~load & valid_q);
    assign out_valid = valid_q[NGRP-1];
    assign Sum       = sum_o_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] s_in;
        logic             c_in;
        logic [GROUP:0]   cc;
        logic [GROUP-1:0] s_grp;
        logic [WIDTH-1:0] sum_d;

        if (k == 0) begin : g_first
            assign a_in         = A;
            assign b_in         = beff;
            assign s_in         = '0;
            assign c_in         = c0;
            assign stage_vin[k] = in_valid;
        end else begin : g_next
            assign a_in         = a_q[k-1];
            assign b_in         = b_q[k-1];
            assign s_in         = sum_q[k-1];
            assign c_in         = c_q[k-1];
            assign stage_vin[k] = valid_q[k-1];
        end

        assign cc    = cla_carries(a_in[k*GROUP +: GROUP], b_in[k*GROUP +: GROUP], c_in);
        assign s_grp = a_in[k*GROUP +: GROUP] ^ b_in[k*GROUP +: GROUP] ^ cc[GROUP-1:0];

        always_comb begin
            sum_d                   = s_in;
            sum_d[k*GROUP +: GROUP] = s_grp;
        end

        if (k < NGRP - 1) begin : g_mid
            always_ff @(posedge clk) begin
                if (load[k]) begin
                    a_q[k]   <= a_in;
                    b_q[k]   <= b_in;
                    sum_q[k] <= sum_d;
                    c_q[k]   <= cc[GROUP];
                end
            end
        end else begin : g_last
            // Only a valid arrival may overwrite the outputs, so bubbles never leak stale data.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_o_q <= '0;
                    cout_q  <= 1'b0;
                    ovf_q   <= 1'b0;
                end else if (load[k] && stage_vin[k]) begin
                    sum_o_q <= sum_d;
                    cout_q  <= cc[GROUP];
                    ovf_q   <= cc[GROUP] ^ cc[GROUP-1];
                end
            end
        end
    end

    if (NGRP == 1) begin : g_no_mid
        assign a_q[0]   = '0;
        assign b_q[0]   = '0;
        assign sum_q[0] = '0;
        assign c_q      = '0;
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Self-checking bench for cla_adder_pipe (WIDTH=16, GROUP=4): directed vectors, stall, reset, random traffic.
module tb_cla_adder_pipe;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         Sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Ovf;

    int n_vec;
    int n_miss;
    int out_count;

    logic [W+1:0] q[$];
    logic         prev_stall;
    logic [W+1:0] prev_out;
    logic         saw_full;
    logic         rnd_done;

    cla_adder_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {ovf, cout, sum} from integer arithmetic and operand signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin, input logic sub);
        logic [W-1:0] be;
        logic [W:0]   full;
        logic         ov;
        be   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ov   = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return {ov, full[W], full[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {13'd0, out_valid, Ovf, Cout, Sum}, {13'd0, 1'b1, prev_out});
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("spurious_out_valid", {31'd0, out_valid}, 32'd0);
                end else if (out_ready) begin
                    check("result", {14'd0, Ovf, Cout, Sum}, {14'd0, q.pop_front()});
                    out_count++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {Ovf, Cout, Sum};
            if (in_valid && in_ready) q.push_back(model(A, B, Cin, Sub));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int waited;
        in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 32'(waited), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run_directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic sub, input logic [W+1:0] exp);
        int lat;
        check({name, "_model"}, {14'd0, model(a, b, cin, sub)}, {14'd0, exp});
        send(a, b, cin, sub);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check({name, "_latency"}, 32'(lat), 32'd4);
        check({name, "_result"}, {14'd0, Ovf, Cout, Sum}, {14'd0, exp});
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int base;
        n_vec = 0; n_miss = 0; out_count = 0;
        prev_stall = 1'b0; saw_full = 1'b0; rnd_done = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;

        #12;
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_outputs", {14'd0, Ovf, Cout, Sum}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_directed("t1_add",       16'h0002, 16'h000F, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0011});
        run_directed("t2_carry",     16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_directed("t2_cin",       16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000});
        run_directed("t3_ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        run_directed("t3_ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, {1'b1, 1'b1, 16'h0000});
        run_directed("t4_sub",       16'h000E, 16'h0005, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0009});
        run_directed("t4_sub_cin",   16'h0005, 16'h000E, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFF7});

        // 10 back-to-back operations with the consumer stalled in cycles 3..8.
        base = out_count;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(16'(i * 16'h1111), 16'(16'h0F0F + i * 16'h0123), 1'(i % 2), 1'(i / 5));
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    out_ready = !(c >= 3 && c <= 8);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (!in_ready) saw_full = 1'b1;
                end
            end
        join
        wait_drain("t5_drain");
        check("t5_in_ready_fell", {31'd0, saw_full}, 32'd1);
        check("t5_count", 32'(out_count - base), 32'd10);

        // Reset with three operations in flight.
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        send(16'h4321, 16'h0101, 1'b1, 1'b0);
        send(16'h0F00, 16'h00F0, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("t6_pre_reset_valid", {31'd0, out_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_async_outputs", {14'd0, Ovf, Cout, Sum}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("t6_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        check("t6_no_stale", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Random traffic against the model.
        base = out_count;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain("t6_rand_drain");
        check("t6_rand_count", 32'(out_count - base), 32'd1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
